// File: rtl/melody_sequencer.sv
// melody_sequencer
//   Autonomous note source for the tone organ. Walks a fixed 16-entry melody
//   ROM at a programmable tempo and drives the organ's Gray-coded note select.
//   The last GAP_CYCLES of every entry are silent, so repeated notes are heard
//   as separate notes.
//
// Ports
//   CLK_50M     in   system clock
//   Reset       in   asynchronous active-low reset
//   play        in   level: 1 = run, 0 = pause/stop
//   restart     in   one-cycle pulse: return to entry 0
//   loop_en     in   1 = wrap to entry 0 after the last entry
//   note_code   out  Gray note select (0000 = silence)
//   step_index  out  current ROM entry
//   playing     out  high while in PLAYING
//   beat_tick   out  one-cycle pulse at each beat boundary while PLAYING
//   song_done   out  one-cycle pulse when the last entry completes
//   fsm_state   out  current FSM state (debug visibility)
//
// Handshake/timing: there is no valid/ready pair. Inputs are sampled on each
// rising clock edge; every output is a register loaded from the next-state
// values, so outputs describe the state entered at that same edge.
module melody_sequencer #(
    parameter int BEAT_DIV   = 12_500_000,
    parameter int GAP_CYCLES = 1_250_000,
    parameter int SONG_LEN   = 16
) (
    input  logic       CLK_50M,
    input  logic       Reset,
    input  logic       play,
    input  logic       restart,
    input  logic       loop_en,
    output logic [3:0] note_code,
    output logic [3:0] step_index,
    output logic       playing,
    output logic       beat_tick,
    output logic       song_done,
    output logic [1:0] fsm_state
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PLAYING = 2'd1;
    localparam logic [1:0] ST_PAUSED  = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic [31:0] BEAT_LEN  = 32'(BEAT_DIV);
    localparam logic [31:0] GAP_LEN   = 32'(GAP_CYCLES);
    localparam logic [3:0]  LAST_STEP = 4'(SONG_LEN - 1);

    // Each entry: {gray code[3:0], duration in beats[2:0], rest flag}
    localparam logic [7:0] MELODY [16] = '{
        {4'b0001, 3'd1, 1'b0},   // 0  Do
        {4'b0011, 3'd1, 1'b0},   // 1  Re
        {4'b0111, 3'd1, 1'b0},   // 2  Mi
        {4'b0101, 3'd1, 1'b0},   // 3  Fa
        {4'b1101, 3'd1, 1'b0},   // 4  So
        {4'b1111, 3'd1, 1'b0},   // 5  La
        {4'b1011, 3'd1, 1'b0},   // 6  Si
        {4'b1001, 3'd1, 1'b0},   // 7  DO2
        {4'b0000, 3'd2, 1'b1},   // 8  rest
        {4'b1011, 3'd1, 1'b0},   // 9  Si
        {4'b1111, 3'd1, 1'b0},   // 10 La
        {4'b1101, 3'd1, 1'b0},   // 11 So
        {4'b0101, 3'd1, 1'b0},   // 12 Fa
        {4'b0111, 3'd1, 1'b0},   // 13 Mi
        {4'b0011, 3'd1, 1'b0},   // 14 Re
        {4'b0001, 3'd4, 1'b0}    // 15 Do (long final note)
    };

    logic [1:0]  state,    state_n;
    logic [3:0]  step,     step_n;
    logic [31:0] cyc,      cyc_n;
    logic [31:0] beat_cnt, beat_n;
    logic        tick_n;
    logic        done_n;
    logic [3:0]  code_n;

    logic [31:0] cur_len;
    logic [31:0] nxt_len;
    logic [7:0]  cur_entry;
    logic [7:0]  nxt_entry;

    assign cur_entry = MELODY[step];
    assign nxt_entry = MELODY[step_n];
    assign cur_len   = 32'(cur_entry[3:1]) * BEAT_LEN;
    assign nxt_len   = 32'(nxt_entry[3:1]) * BEAT_LEN;

    assign fsm_state = state;

    always_comb begin
        state_n = state;
        step_n  = step;
        cyc_n   = cyc;
        beat_n  = beat_cnt;
        tick_n  = 1'b0;
        done_n  = 1'b0;

        if (restart) begin
            // Restart beats pause and end-of-entry: no advance, no song_done.
            step_n  = 4'd0;
            cyc_n   = 32'd0;
            beat_n  = 32'd0;
            state_n = play ? ST_PLAYING : ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (play) begin
                        state_n = ST_PLAYING;
                        step_n  = 4'd0;
                        cyc_n   = 32'd0;
                        beat_n  = 32'd0;
                    end
                end
                ST_PLAYING: begin
                    if (!play) begin
                        // Counters hold; an end-of-entry advance is deferred
                        // until play returns.
                        state_n = ST_PAUSED;
                    end else begin
                        if (beat_cnt == BEAT_LEN - 32'd1) begin
                            beat_n = 32'd0;
                            tick_n = 1'b1;
                        end else begin
                            beat_n = beat_cnt + 32'd1;
                        end

                        if (cyc == cur_len - 32'd1) begin
                            cyc_n = 32'd0;
                            if (step == LAST_STEP) begin
                                done_n = 1'b1;
                                if (loop_en) begin
                                    step_n = 4'd0;
                                end else begin
                                    state_n = ST_DONE;
                                end
                            end else begin
                                step_n = step + 4'd1;
                            end
                        end else begin
                            cyc_n = cyc + 32'd1;
                        end
                    end
                end
                ST_PAUSED: begin
                    if (play) begin
                        state_n = ST_PLAYING;
                    end
                end
                ST_DONE: begin
                    // Replay needs play to fall first.
                    if (!play) begin
                        state_n = ST_IDLE;
                        step_n  = 4'd0;
                        cyc_n   = 32'd0;
                        beat_n  = 32'd0;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    step_n  = 4'd0;
                    cyc_n   = 32'd0;
                    beat_n  = 32'd0;
                end
            endcase
        end
    end

    // Sound only while playing a non-rest entry outside its trailing gap.
    always_comb begin
        code_n = 4'b0000;
        if (state_n == ST_PLAYING && !nxt_entry[0] && cyc_n < nxt_len - GAP_LEN) begin
            code_n = nxt_entry[7:4];
        end
    end

    always_ff @(posedge CLK_50M or negedge Reset) begin
        if (!Reset) begin
            state      <= ST_IDLE;
            step       <= 4'd0;
            cyc        <= 32'd0;
            beat_cnt   <= 32'd0;
            note_code  <= 4'b0000;
            step_index <= 4'd0;
            playing    <= 1'b0;
            beat_tick  <= 1'b0;
            song_done  <= 1'b0;
        end else begin
            state      <= state_n;
            step       <= step_n;
            cyc        <= cyc_n;
            beat_cnt   <= beat_n;
            note_code  <= code_n;
            step_index <= step_n;
            playing    <= (state_n == ST_PLAYING);
            beat_tick  <= tick_n;
            song_done  <= done_n;
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// tb_melody_sequencer
//   Drives melody_sequencer with directed scenarios and random play/restart/
//   loop/reset traffic. The reference model tracks the song as a single
//   position on a flattened 160-cycle timeline rather than entry/cycle pairs.
module tb_melody_sequencer;

    localparam int BD       = 8;
    localparam int GAP      = 2;
    localparam int SONG_CYC = 160;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n;
    logic       play, restart, loop_en;
    logic [3:0] note_code, step_index;
    logic       playing, beat_tick, song_done;
    logic [1:0] fsm_state;

    always #5 clk = ~clk;

    melody_sequencer #(
        .BEAT_DIV  (BD),
        .GAP_CYCLES(GAP),
        .SONG_LEN  (16)
    ) dut (
        .CLK_50M   (clk),
        .Reset     (rst_n),
        .play      (play),
        .restart   (restart),
        .loop_en   (loop_en),
        .note_code (note_code),
        .step_index(step_index),
        .playing   (playing),
        .beat_tick (beat_tick),
        .song_done (song_done),
        .fsm_state (fsm_state)
    );

    // ---------------- reference model ----------------
    // m_mode: 0 idle, 1 playing, 2 paused, 3 done. m_pos: cycle in song.
    logic [3:0] flat_code [SONG_CYC];
    int         flat_step [SONG_CYC];
    int         m_mode;
    int         m_pos;
    logic       m_tick, m_done;

    logic [10:0] exp_q[$];   // {code, step, playing, tick, done}

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    task automatic build_song();
        int codes [16] = '{1, 3, 7, 5, 13, 15, 11, 9, 0, 11, 15, 13, 5, 7, 3, 1};
        int beats [16] = '{1, 1, 1, 1, 1, 1, 1, 1, 2, 1, 1, 1, 1, 1, 1, 4};
        int p = 0;
        for (int e = 0; e < 16; e++) begin
            int len = beats[e] * BD;
            for (int k = 0; k < len; k++) begin
                flat_code[p] = (e == 8 || k >= len - GAP) ? 4'd0 : 4'(codes[e]);
                flat_step[p] = e;
                p++;
            end
        end
    endtask

    task automatic push_expected();
        logic [3:0] c, s;
        c = (m_mode == 1) ? flat_code[m_pos] : 4'd0;
        if (m_mode == 0)      s = 4'd0;
        else if (m_mode == 3) s = 4'd15;
        else                  s = 4'(flat_step[m_pos]);
        exp_q.push_back({c, s, (m_mode == 1), m_tick, m_done});
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_pos  = 0;
        m_tick = 1'b0;
        m_done = 1'b0;
        push_expected();
    endtask

    task automatic model_step(input logic p, input logic r, input logic l);
        m_tick = 1'b0;
        m_done = 1'b0;
        if (r) begin
            m_pos  = 0;
            m_mode = p ? 1 : 0;
        end else begin
            case (m_mode)
                0: if (p) begin m_mode = 1; m_pos = 0; end
                1: begin
                    if (!p) m_mode = 2;
                    else begin
                        if (m_pos % BD == BD - 1) m_tick = 1'b1;
                        if (m_pos == SONG_CYC - 1) begin
                            m_done = 1'b1;
                            if (l) m_pos = 0;
                            else   m_mode = 3;
                        end else begin
                            m_pos++;
                        end
                    end
                end
                2: if (p) m_mode = 1;
                default: if (!p) begin m_mode = 0; m_pos = 0; end
            endcase
        end
        push_expected();
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cycle, got, exp);
        end
    endtask

    task automatic compare();
        logic [10:0] e;
        e = exp_q.pop_front();
        chk("note_code",  {28'd0, note_code},  {28'd0, e[10:7]});
        chk("step_index", {28'd0, step_index}, {28'd0, e[6:3]});
        chk("playing",    {31'd0, playing},    {31'd0, e[2]});
        chk("beat_tick",  {31'd0, beat_tick},  {31'd0, e[1]});
        chk("song_done",  {31'd0, song_done},  {31'd0, e[0]});
    endtask

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; inputs are stable for the next edge.
    task automatic cyc_step(input logic p, input logic r, input logic l);
        play    = p;
        restart = r;
        loop_en = l;
        @(posedge clk);
        cycle++;
        model_step(p, r, l);
        #1;
        compare();
    endtask

    task automatic run(input int n, input logic p, input logic l);
        for (int i = 0; i < n; i++) cyc_step(p, 1'b0, l);
    endtask

    task automatic run_to_pos(input int target, input logic l);
        logic hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            if (m_mode == 1 && m_pos == target) hit = 1'b1;
            else cyc_step(1'b1, 1'b0, l);
        end
        chk("reach_pos", {31'd0, hit}, 32'd1);
    endtask

    // Asynchronous reset asserted between edges, held across one edge.
    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        compare();
        @(posedge clk);
        cycle++;
        #1;
        rst_n = 1'b1;
        model_reset();
        compare();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic cur_play, cur_loop;
        build_song();
        rst_n   = 1'b0;
        play    = 1'b0;
        restart = 1'b0;
        loop_en = 1'b0;
        #1;
        model_reset();
        compare();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Idle with play low.
        run(4, 1'b0, 1'b0);

        // Full song, no loop, then DONE held, then back to IDLE.
        run(170, 1'b1, 1'b0);
        run(10, 1'b1, 1'b0);
        run(4, 1'b0, 1'b0);

        // Pause at step 3, cyc 3 for 20 cycles, then resume through step 4.
        run_to_pos(27, 1'b0);
        run(20, 1'b0, 1'b0);
        run(16, 1'b1, 1'b0);

        // Mid-stream asynchronous reset, then stay idle.
        async_reset();
        run(3, 1'b0, 1'b0);

        // Looping playback across the wrap.
        run(200, 1'b1, 1'b1);

        // Restart on the end-of-entry cycle of step 5.
        cyc_step(1'b1, 1'b1, 1'b0);
        run_to_pos(47, 1'b0);
        cyc_step(1'b1, 1'b1, 1'b0);
        run(10, 1'b1, 1'b0);

        // Restart with play low returns to IDLE.
        cyc_step(1'b0, 1'b1, 1'b0);
        run(3, 1'b0, 1'b0);

        // Pause exactly on an end-of-entry cycle, then resume.
        cyc_step(1'b1, 1'b1, 1'b0);
        run_to_pos(15, 1'b0);
        run(5, 1'b0, 1'b0);
        run(12, 1'b1, 1'b0);

        // Random traffic.
        cur_play = 1'b1;
        cur_loop = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 999);
            if (r < 5) begin
                async_reset();
            end else begin
                if ($urandom_range(0, 99) < 3) cur_play = ~cur_play;
                if ($urandom_range(0, 99) < 1) cur_loop = ~cur_loop;
                cyc_step(cur_play, ($urandom_range(0, 99) < 2), cur_loop);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL timeout cycle=%0d got=running exp=finished", cycle);
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
